// File: rtl/code_mem_loadable.sv
// Run-time loadable i281 instruction memory; CODE_MEM_CHECKSUM_EN adds a trailing checksum word per load.
// Fetch latency 1 cycle; ld_ready high for the whole session, ld_busy blocks fetch.
module code_mem_loadable #(
  parameter  int WORD_W = 16,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [WORD_W-1:0] fetch_instr,
  output logic              fetch_valid,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

`ifdef CODE_MEM_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                we;
  logic [ADDR_W:0]     cnt_eff;
  logic                xfer;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   fetch_instr_q;
  logic                fetch_valid_q;
`ifdef CODE_MEM_CHECKSUM_EN
  logic [WORD_W-1:0]   sum_q, sum_d;
`endif

  // Zero and oversized counts both mean "fill the whole memory".
  assign cnt_eff = (ld_count == '0 || ld_count > DEPTH_C) ? DEPTH_C : ld_count;

  assign ld_ready = (state_q != IDLE);
  assign ld_busy  = (state_q != IDLE);
  assign xfer     = ld_valid && ld_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we      = 1'b0;
`ifdef CODE_MEM_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          rem_d   = cnt_eff;
          ptr_d   = '0;
          err_d   = 1'b0;
`ifdef CODE_MEM_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (ld_start) err_d = 1'b1;
        if (xfer) begin
          we    = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - (ADDR_W+1)'(1);
`ifdef CODE_MEM_CHECKSUM_EN
          sum_d = sum_q + ld_data;
          if (rem_q == (ADDR_W+1)'(1)) state_d = CHECK;
`else
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef CODE_MEM_CHECKSUM_EN
      CHECK: begin
        if (ld_start) err_d = 1'b1;
        if (xfer) begin
          if (ld_data != sum_q) err_d = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef CODE_MEM_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef CODE_MEM_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Flop-based storage so reset can restore the all-NOP program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ptr_q] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_instr_q <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_en && !ld_busy;
      if (fetch_en && !ld_busy) fetch_instr_q <= mem_q[fetch_addr];
    end
  end

  assign fetch_instr = fetch_instr_q;
  assign fetch_valid = fetch_valid_q;
  assign ld_done     = done_q;
  assign ld_err      = err_q;

endmodule

// File: tb/tb_code_mem_loadable.sv
// Directed bench for code_mem_loadable (DEPTH 16, WORD_W 16); checksum cases only with CODE_MEM_CHECKSUM_EN.
module tb_code_mem_loadable;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [3:0]  fetch_addr;
  logic [15:0] fetch_instr;
  logic        fetch_valid;
  logic        ld_start;
  logic [4:0]  ld_count;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_mem [16];
  logic [15:0] wr_w    [16];

  code_mem_loadable #(.WORD_W(16), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .ld_start(ld_start), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input int a);
    fetch_en   = 1'b1;
    fetch_addr = 4'(a);
    tick();
    chk($sformatf("%s_instr%0d", tag, a), 32'(fetch_instr), 32'(exp_mem[a]));
    chk($sformatf("%s_vld%0d", tag, a), 32'(fetch_valid), 32'd1);
    fetch_en = 1'b0;
  endtask

  // Streams wr_w[0..n-1] (plus checksum word when enabled); bad_at pulses ld_start on that transfer.
  task automatic do_load(input string tag, input int cnt, input int n, input bit gap,
                         input int bad_at, input bit sum_bad, input bit fetch_during,
                         input bit exp_err);
    logic [15:0] sum;
    logic [15:0] w;
    int nx, busy_bad, fv_bad, early_done;
    sum = '0; busy_bad = 0; fv_bad = 0; early_done = 0;
    nx = n;
`ifdef CODE_MEM_CHECKSUM_EN
    nx = n + 1;
`endif
    ld_count = 5'(cnt);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(ld_busy), 32'd1);
    chk({tag, "_ready"}, 32'(ld_ready), 32'd1);
    fetch_en   = fetch_during;
    fetch_addr = 4'd0;
    for (int i = 0; i < nx; i++) begin
      if (gap) begin
        ld_valid = 1'b0;
        tick();
        if (!ld_busy) busy_bad++;
        if (ld_done) early_done++;
        if (fetch_valid) fv_bad++;
      end
      if (i < n) begin
        w = wr_w[i];
        sum = sum + w;
      end else begin
        w = sum + 16'(sum_bad);
      end
      ld_valid = 1'b1;
      ld_data  = w;
      ld_start = (i == bad_at);
      tick();
      ld_start = 1'b0;
      if (fetch_valid) fv_bad++;
      if (i < nx - 1) begin
        if (!ld_busy) busy_bad++;
        if (ld_done) early_done++;
      end
    end
    ld_valid = 1'b0;
    fetch_en = 1'b0;
    chk({tag, "_done"}, 32'(ld_done), 32'd1);
    chk({tag, "_busy_fall"}, 32'(ld_busy), 32'd0);
    chk({tag, "_err"}, 32'(ld_err), 32'(exp_err));
    tick();
    chk({tag, "_done_pulse"}, 32'(ld_done), 32'd0);
    chk({tag, "_busy_hold"}, 32'(busy_bad), 32'd0);
    chk({tag, "_early_done"}, 32'(early_done), 32'd0);
    if (fetch_during) chk({tag, "_fetch_blocked"}, 32'(fv_bad), 32'd0);
    for (int i = 0; i < n; i++) exp_mem[i] = wr_w[i];
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    ld_start = 1'b0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    #12;
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    chk("rst_fvld", 32'(fetch_valid), 32'd0);
    chk("rst_finstr", 32'(fetch_instr), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) fetch_chk("rst_mem", a);
    tick();
    chk("idle_fvld", 32'(fetch_valid), 32'd0);

    // Three back-to-back words; addr 3 must stay NOP.
    wr_w[0] = 16'h3000; wr_w[1] = 16'h3400; wr_w[2] = 16'h3C04;
    do_load("ld3", 3, 3, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) fetch_chk("ld3_mem", a);
    chk("ld3_addr3_nop", 32'(exp_mem[3]), 32'h0);

    // Count 0 means full depth; gapped valid, fetch requested throughout.
    for (int i = 0; i < 16; i++) wr_w[i] = 16'hA000 + 16'(i * 16'h0111);
    do_load("full", 0, 16, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < 16; a++) fetch_chk("full_mem", a);

    // ld_start mid-session flags an error but the load still lands.
    wr_w[0] = 16'h1111; wr_w[1] = 16'h2222; wr_w[2] = 16'h3333;
    do_load("dblstart", 3, 3, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    chk("dblstart_err_sticky", 32'(ld_err), 32'd1);
    for (int a = 0; a < 3; a++) fetch_chk("dblstart_mem", a);
    wr_w[0] = 16'h5A5A;
    do_load("clrerr", 1, 1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    fetch_chk("clrerr_mem", 0);
    fetch_chk("clrerr_mem", 1);

`ifdef CODE_MEM_CHECKSUM_EN
    wr_w[0] = 16'h0001; wr_w[1] = 16'h0002;
    do_load("cs_ok", 2, 2, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    wr_w[0] = 16'h0001; wr_w[1] = 16'h0002;
    do_load("cs_bad", 2, 2, 1'b0, -1, 1'b1, 1'b0, 1'b1);
    fetch_chk("cs_bad_mem", 0);
    fetch_chk("cs_bad_mem", 1);
    fetch_chk("cs_bad_mem", 2);
`endif

    // Reset after 2 of 4 words: everything back to power-on state.
    ld_count = 5'd4;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 16'hBEEF;
    tick();
    ld_data  = 16'hCAFE;
    tick();
    ld_valid = 1'b0;
    chk("mid_busy_before", 32'(ld_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(ld_busy), 32'd0);
    chk("mid_ready", 32'(ld_ready), 32'd0);
    chk("mid_err", 32'(ld_err), 32'd0);
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ld_done) dones++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
    for (int a = 0; a < 16; a++) fetch_chk("mid_mem", a);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
